// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: one-outstanding memory requester feeding a 2-entry decode buffer
module ifetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Redirect,
  input  logic [63:0] i_RedirectPC_64,
  output logic        o_IMemReq,
  output logic [63:0] o_IMemAddr_64,
  input  logic        i_IMemGnt,
  input  logic        i_IMemRvalid,
  input  logic [31:0] i_IMemRdata_32,
  input  logic        i_IMemErr,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [63:0] o_PC_64,
  output logic [31:0] o_Inst_32,
  output logic [1:0]  o_Fault_2
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL, S_HALT} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_nxt;
  logic [63:0] pc, out_pc;
  logic [63:0] buf_pc    [2];
  logic [31:0] buf_inst  [2];
  logic [1:0]  buf_fault [2];
  logic        head;
  logic [1:0]  count;

  logic        aligned, room, grant, pop, push, tail;
  logic [63:0] push_pc;
  logic [31:0] push_inst;
  logic [1:0]  push_fault;

  assign aligned = (pc[1:0] == 2'b00);
  assign room    = (count != 2'd2);
  // Outstanding is zero whenever state is REQ, so count<2 alone keeps count+outstanding <= 2.
  assign o_IMemReq     = i_Rst_n & (state == S_REQ) & aligned & room & ~i_Redirect;
  assign o_IMemAddr_64 = pc;
  assign grant         = o_IMemReq & i_IMemGnt;
  assign pop           = (count != 2'd0) & i_Ready;
  assign tail          = head ^ count[0];

  assign o_Valid   = (count != 2'd0);
  assign o_PC_64   = buf_pc[head];
  assign o_Inst_32 = buf_inst[head];
  assign o_Fault_2 = buf_fault[head];

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    push_pc    = out_pc;
    push_inst  = NOP;
    push_fault = 2'b00;
    if (i_Redirect) begin
      case (state)
        S_WAIT:  state_nxt = i_IMemRvalid ? S_REQ : S_KILL;
        S_KILL:  state_nxt = S_KILL;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (grant) begin
            state_nxt = S_WAIT;
          end else if (!aligned && room) begin
            push       = 1'b1;
            push_pc    = pc;
            push_fault = 2'b01;
            state_nxt  = S_HALT;
          end
        end
        S_WAIT: begin
          if (i_IMemRvalid) begin
            push = 1'b1;
            if (i_IMemErr) begin
              push_fault = 2'b10;
              state_nxt  = S_HALT;
            end else begin
              push_inst = i_IMemRdata_32;
              state_nxt = S_REQ;
            end
          end
        end
        S_KILL: begin
          if (i_IMemRvalid) state_nxt = S_REQ;
        end
        default: state_nxt = S_HALT;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      out_pc <= '0;
      head   <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= '0;
        buf_inst[i]  <= '0;
        buf_fault[i] <= '0;
      end
    end else if (i_Redirect) begin
      // Redirect discards everything in flight this cycle, including any pop or push.
      state <= state_nxt;
      pc    <= i_RedirectPC_64;
      head  <= 1'b0;
      count <= 2'd0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        out_pc <= pc;
        pc     <= pc + 64'd4;
      end
      if (push) begin
        buf_pc[tail]    <= push_pc;
        buf_inst[tail]  <= push_inst;
        buf_fault[tail] <= push_fault;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for ifetch
module tb_ifetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        valid;
  logic        ready;
  logic [63:0] pc_out;
  logic [31:0] inst_out;
  logic [1:0]  fault_out;

  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  logic        use_force = 1'b0;
  logic [31:0] force_word = 32'hDEAD_BEEF;
  logic [63:0] err_addr = 64'h0;

  logic        g, pend, p_err;
  logic [63:0] ga;
  logic [31:0] p_data;
  int          cnt;

  ifetch dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Redirect(redirect), .i_RedirectPC_64(redirect_pc),
    .o_IMemReq(mem_req), .o_IMemAddr_64(mem_addr), .i_IMemGnt(mem_gnt),
    .i_IMemRvalid(mem_rvalid), .i_IMemRdata_32(mem_rdata), .i_IMemErr(mem_err),
    .o_Valid(valid), .i_Ready(ready), .o_PC_64(pc_out), .o_Inst_32(inst_out),
    .o_Fault_2(fault_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Memory responder: word = address[31:0] + 1 unless forced; latency taken at grant time.
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
    pend       = 1'b0;
    cnt        = 0;
    forever begin
      @(negedge clk);
      #3;
      g  = mem_req & mem_gnt;
      ga = mem_addr;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      mem_err    = 1'b0;
      if (g) begin
        pend   = 1'b1;
        cnt    = lat;
        p_data = use_force ? force_word : ga[31:0] + 32'd1;
        p_err  = (ga == err_addr);
      end
      if (pend) begin
        if (cnt <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = p_data;
          mem_err    = p_err;
          pend       = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic redirect_to(input logic [63:0] target);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = target;
    @(negedge clk);
    redirect = 1'b0;
    #1;
  endtask

  // Waits (bounded) for an entry, checks it, then lets the next edge consume it.
  task automatic pop_chk(input string tag, input logic [63:0] epc, input logic [31:0] einst,
                         input logic [1:0] efault);
    int n = 0;
    while (!valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_valid"}, 64'(valid), 64'd1);
    chk({tag, "_pc"}, pc_out, epc);
    chk({tag, "_inst"}, 64'(inst_out), 64'(einst));
    chk({tag, "_fault"}, 64'(fault_out), 64'(efault));
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_gnt     = 1'b1;
    ready       = 1'b0;
    cyc(3);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_pc", pc_out, 64'd0);
    chk("rst_inst", 64'(inst_out), 64'd0);
    chk("rst_fault", 64'(fault_out), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_req", 64'(mem_req), 64'd1);
    chk("first_addr", mem_addr, 64'h8000_0000);
    ready = 1'b1;
    pop_chk("seq0", 64'h8000_0000, 32'h8000_0001, 2'b00);
    pop_chk("seq1", 64'h8000_0004, 32'h8000_0005, 2'b00);
    pop_chk("seq2", 64'h8000_0008, 32'h8000_0009, 2'b00);

    // Backpressure: buffer fills to two and requests stop.
    ready = 1'b0;
    cyc(10);
    chk("bp_valid", 64'(valid), 64'd1);
    chk("bp_req", 64'(mem_req), 64'd0);
    ready = 1'b1;
    pop_chk("bp0", 64'h8000_000C, 32'h8000_000D, 2'b00);
    pop_chk("bp1", 64'h8000_0010, 32'h8000_0011, 2'b00);
    pop_chk("bp2", 64'h8000_0014, 32'h8000_0015, 2'b00);

    // Redirect during WAIT, late response must be discarded.
    ready = 1'b0;
    cyc(8);
    lat       = 3;
    use_force = 1'b1;
    redirect_to(64'h8000_0200);
    chk("k_req200", 64'(mem_req), 64'd1);
    chk("k_addr200", mem_addr, 64'h8000_0200);
    chk("k_flushed", 64'(valid), 64'd0);
    @(negedge clk);
    use_force   = 1'b0;
    lat         = 1;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_0100;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("kill_noreq0", 64'(mem_req), 64'd0);
    cyc(1);
    chk("kill_noreq1", 64'(mem_req), 64'd0);
    ready = 1'b1;
    pop_chk("after_kill", 64'h8000_0100, 32'h8000_0101, 2'b00);

    // Redirect coincident with the response: no KILL, request to target next cycle.
    ready = 1'b0;
    cyc(8);
    redirect_to(64'h8000_0400);
    chk("co_req400", 64'(mem_req), 64'd1);
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = 64'h8000_0300;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    chk("co_req", 64'(mem_req), 64'd1);
    chk("co_addr", mem_addr, 64'h8000_0300);
    chk("co_flushed", 64'(valid), 64'd0);
    ready = 1'b1;
    pop_chk("co_entry", 64'h8000_0300, 32'h8000_0301, 2'b00);

    // Misaligned redirect target.
    ready = 1'b0;
    cyc(8);
    redirect_to(64'h8000_0102);
    chk("mis_noreq", 64'(mem_req), 64'd0);
    ready = 1'b1;
    pop_chk("mis_entry", 64'h8000_0102, 32'h0000_0013, 2'b01);
    cyc(4);
    chk("mis_halt_valid", 64'(valid), 64'd0);
    chk("mis_halt_req", 64'(mem_req), 64'd0);

    // Access fault, then wrap-around redirect.
    err_addr = 64'h8000_0010;
    redirect_to(64'h8000_0010);
    pop_chk("err_entry", 64'h8000_0010, 32'h0000_0013, 2'b10);
    cyc(4);
    chk("err_halt_valid", 64'(valid), 64'd0);
    chk("err_halt_req", 64'(mem_req), 64'd0);
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_req", 64'(mem_req), 64'd1);
    chk("wrap_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    pop_chk("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFD, 2'b00);
    pop_chk("wrap_zero", 64'h0, 32'h0000_0001, 2'b00);

    // Reset mid-transaction; late response while stalled in REQ is ignored.
    ready = 1'b0;
    cyc(8);
    lat = 3;
    redirect_to(64'h8000_0500);
    chk("mid_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    rst_n   = 1'b0;
    mem_gnt = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_req", 64'(mem_req), 64'd0);
    chk("mid_rst_pc", pc_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_addr", mem_addr, 64'h8000_0000);
    cyc(4);
    chk("late_ignored", 64'(valid), 64'd0);
    chk("late_req", 64'(mem_req), 64'd1);
    lat     = 1;
    mem_gnt = 1'b1;
    ready   = 1'b1;
    pop_chk("post_rst", 64'h8000_0000, 32'h8000_0001, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 i_Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_Redirect  input  1  flush and restart fetch at i_RedirectPC_64 (from branch/jump/trap logic).
REQ-005 i_RedirectPC_64  input  64  redirect target, sampled when i_Redirect=1.
REQ-006 o_IMemReq  output  1  instruction memory read request.
REQ-007 o_IMemAddr_64  output  64  request address; equals current PC.
REQ-008 i_IMemGnt  input  1  request accepted this cycle; meaningful only when o_IMemReq=1.
REQ-009 i_IMemRvalid  input  1  read data valid; exactly one per granted request, earliest one cycle after grant.
REQ-010 i_IMemRdata_32  input  32  instruction word.
REQ-011 i_IMemErr  input  1  access fault, qualified by i_IMemRvalid.
REQ-012 o_Valid  output  1  instruction available to decode.
REQ-013 i_Ready  input  1  decode accepts; transfer when o_Valid & i_Ready.
REQ-014 o_PC_64  output  64  PC of presented instruction.
REQ-015 o_Inst_32  output  32  presented instruction word.
REQ-016 o_Fault_2  output  2  00 none, 01 misaligned PC, 10 access fault.

Function
REQ-017 States: REQ (may request), WAIT (one request outstanding), KILL (outstanding response to be discarded), HALT (faulted, no requests).
REQ-018 At most one memory request outstanding at any time.
REQ-019 Output buffer: 2-entry FIFO of {PC, inst, fault}; outputs driven from head; o_Valid = (count != 0).
REQ-020 o_IMemReq = (state==REQ) & (PC[1:0]==0) & (count < 2) & ~i_Redirect; o_IMemAddr_64 = PC.
REQ-021 o_IMemReq and o_IMemAddr_64 stay stable until i_IMemGnt, unless i_Redirect withdraws the request.
REQ-022 On grant: outstanding PC <= PC; PC <= PC + 4, modulo 2^64 (wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0); REQ -> WAIT.
REQ-023 Issue rule: count + outstanding never exceeds 2, so a push never hits a full FIFO.
REQ-024 WAIT, i_IMemRvalid=1, i_IMemErr=0: push {outstanding PC, i_IMemRdata_32, 00}; -> REQ.
REQ-025 WAIT, i_IMemRvalid=1, i_IMemErr=1: push {outstanding PC, 32'h0000_0013, 10}; -> HALT.
REQ-026 REQ, PC[1:0]!=0, count<2: no request; push {PC, 32'h0000_0013, 01}; -> HALT.
REQ-027 HALT: no requests, no pushes; held until i_Redirect.
REQ-028 Push and pop in same cycle: count unchanged, FIFO order preserved.
REQ-029 Data presented to decode is combinational from buffer only; minimum latency grant-to-o_Valid = response latency + 1 cycle.
REQ-030 i_Redirect has highest priority: FIFO cleared (o_Valid=0 next cycle), PC <= i_RedirectPC_64, and no pop/push that cycle is retained.
REQ-031 Redirect transitions: REQ->REQ; HALT->REQ; KILL->KILL; WAIT->KILL, except WAIT with i_IMemRvalid=1 in the same cycle -> REQ (response dropped).
REQ-032 KILL, i_IMemRvalid=1: response and error discarded, no push; -> REQ.
REQ-033 Redirect with misaligned target: handled by REQ-026 once in REQ.

Reset
REQ-034 While i_Rst_n=0: state=REQ, PC=RESET_PC, count=0, no outstanding, o_Valid=0, o_IMemReq=0, o_PC_64=0, o_Inst_32=0, o_Fault_2=00.
REQ-035 Reset asserted mid-transaction abandons it; a late i_IMemRvalid after release while in REQ is ignored.
REQ-036 First request asserted in the first cycle after i_Rst_n deasserts, address RESET_PC.

Verification
REQ-037 Reset release, memory grants immediately, 1-cycle response, i_Ready=1 -> PCs 0x8000_0000, 0x8000_0004, 0x8000_0008 presented in order with matching words, no gaps beyond one request per response.
REQ-038 i_Ready=0 for 10 cycles -> exactly two buffered entries, o_IMemReq=0 thereafter, no loss/duplication after i_Ready=1.
REQ-039 Redirect to 0x8000_0100 while WAIT, response arrives 3 cycles later with word 0xDEADBEEF -> word discarded, next presented PC 0x8000_0100.
REQ-040 Redirect coincident with i_IMemRvalid in WAIT -> no KILL, next request to target the following cycle.
REQ-041 Redirect to 0x8000_0102 -> no memory request, entry PC 0x8000_0102, o_Inst_32 0x0000_0013, o_Fault_2=01, then HALT until next redirect.
REQ-042 Response with i_IMemErr=1 at PC 0x8000_0010 -> entry o_Fault_2=10, no further requests; PC 64'hFFFF_FFFF_FFFF_FFFC redirect -> next request address 0.
